// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file (regfile_mp).
package regfile_pkg;

  typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

  localparam int unsigned RF_MAX_NRD = 4;

  // Address width for a given depth, never narrower than one bit.
  function automatic int unsigned rf_aw(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every entry once writing zero, then holds READY
// until a clear request restarts the walk from entry 0.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = rf_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RF_CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = RF_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      RF_READY: begin
        if (clr_req) begin
          state_d = RF_CLEAR;
          cnt_d   = '0;
        end
      end
    endcase
  end

  assign clr_we   = (state_q == RF_CLEAR);
  assign clr_addr = cnt_q;
  assign ready    = (state_q == RF_READY);

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file with NRD registered read ports and a hardware
// clear sequencer. Define REGFILE_BYPASS_EN for write-first same-cycle reads.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int unsigned DW       = 32,
  parameter  int unsigned DEPTH    = 32,
  parameter  int unsigned NRD      = 2,
  parameter  int unsigned ZERO_REG = 1,
  localparam int unsigned AW       = rf_aw(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              ready,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DW-1:0]     wdata,
  input  logic [NRD*AW-1:0] raddr,
  output logic [NRD*DW-1:0] rdata
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  if (NRD < 1 || NRD > RF_MAX_NRD) begin : g_bad_nrd
    $error("regfile_mp: NRD out of range");
  end

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  regfile_clr_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_req  (clr_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  logic [AW-1:0]  ra [NRD];
  logic           wr_inrange;
  logic [NRD-1:0] rd_inrange;

  for (genvar i = 0; i < NRD; i++) begin : g_ra
    assign ra[i] = raddr[i*AW +: AW];
  end

  // A power-of-two depth makes every address legal, so no compare is built.
  if (DEPTH == (1 << AW)) begin : g_pow2
    assign wr_inrange = 1'b1;
    assign rd_inrange = '1;
  end else begin : g_npow2
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
    assign wr_inrange = ({1'b0, waddr} < DEPTH_W);
    for (genvar i = 0; i < NRD; i++) begin : g_rd
      assign rd_inrange[i] = ({1'b0, ra[i]} < DEPTH_W);
    end
  end

  logic wr_ok;
  assign wr_ok = ready && we && wr_inrange && !(HAS_ZERO && (waddr == '0));

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  always_comb begin
    mem_we    = wr_ok;
    mem_addr  = waddr;
    mem_wdata = wdata;
    if (!ready) begin
      mem_we    = clr_we;
      mem_addr  = clr_addr;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  logic [NRD*DW-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      if (ready && rd_inrange[i] && !(HAS_ZERO && (ra[i] == '0))) begin
        rdata_d[i*DW +: DW] = mem[ra[i]];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (waddr == ra[i])) begin
          rdata_d[i*DW +: DW] = wdata;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  // Gate so the first not-ready cycle after a clear request also reads zero.
  assign rdata = ready ? rdata_q : '0;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a 32-entry zero-reg instance (A) and a
// 24-entry instance with an ordinary r0 (B).
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        clr_req_a, we_a, ready_a;
  logic [4:0]  waddr_a;
  logic [31:0] wdata_a;
  logic [9:0]  raddr_a;
  logic [63:0] rdata_a;

  logic        clr_req_b, we_b, ready_b;
  logic [4:0]  waddr_b;
  logic [31:0] wdata_b;
  logic [9:0]  raddr_b;
  logic [63:0] rdata_b;

  regfile_mp #(.DW(32), .DEPTH(32), .NRD(2), .ZERO_REG(1)) u_dut_a (
    .clk(clk), .rst(rst), .clr_req(clr_req_a), .ready(ready_a),
    .we(we_a), .waddr(waddr_a), .wdata(wdata_a), .raddr(raddr_a), .rdata(rdata_a)
  );

  regfile_mp #(.DW(32), .DEPTH(24), .NRD(2), .ZERO_REG(0)) u_dut_b (
    .clk(clk), .rst(rst), .clr_req(clr_req_b), .ready(ready_b),
    .we(we_b), .waddr(waddr_b), .wdata(wdata_b), .raddr(raddr_b), .rdata(rdata_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  int          q_due [$];
  int          q_sel [$];
  int          q_port[$];
  logic [31:0] q_exp [$];
  string       q_tag [$];

  task automatic rd(input int sel, input int port, input logic [4:0] addr,
                    input logic [31:0] exp, input string tag);
    if (sel == 0) raddr_a[port*5 +: 5] = addr;
    else          raddr_b[port*5 +: 5] = addr;
    q_due.push_back(cyc + 1);
    q_sel.push_back(sel);
    q_port.push_back(port);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  int          m_due, m_sel, m_port;
  logic [31:0] m_exp, m_act;
  string       m_tag;

  always @(negedge clk) begin
    while (q_due.size() > 0 && q_due[0] <= cyc) begin
      m_due  = q_due.pop_front();
      m_sel  = q_sel.pop_front();
      m_port = q_port.pop_front();
      m_exp  = q_exp.pop_front();
      m_tag  = q_tag.pop_front();
      m_act  = (m_sel == 0) ? rdata_a[m_port*32 +: 32] : rdata_b[m_port*32 +: 32];
      if (m_due != cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: response missed, due cycle %0d seen at %0d", m_tag, m_due, cyc);
      end else begin
        check(m_tag, m_act, m_exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] b_exp(input int a);
    case (a)
      0:       return 32'h0000_1234;
      6:       return 32'h0000_0066;
      23:      return 32'h2323_2323;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n, na, nb;
  bit done;

  initial begin
    clr_req_a = 0; we_a = 0; waddr_a = '0; wdata_a = '0; raddr_a = '0;
    clr_req_b = 0; we_b = 0; waddr_b = '0; wdata_b = '0; raddr_b = '0;

    // Reset state
    repeat (3) step();
    check("rst_ready_a", 32'(ready_a), 32'd0);
    check("rst_ready_b", 32'(ready_b), 32'd0);
    check("rst_rdata_a0", rdata_a[31:0], 32'h0);
    check("rst_rdata_a1", rdata_a[63:32], 32'h0);

    // Clear after release: ready after exactly DEPTH cycles
    rst = 1'b1;
    n = 0; na = -1; nb = -1;
    while ((na < 0 || nb < 0) && n < 100) begin
      step();
      n++;
      if (ready_a && na < 0) na = n;
      if (ready_b && nb < 0) nb = n;
    end
    check("init_clear_cycles_a", 32'(na), 32'd32);
    check("init_clear_cycles_b", 32'(nb), 32'd24);

    for (int k = 0; k < 16; k++) begin
      rd(0, 0, 5'(2*k),   32'h0, "init_zero_a_p0");
      rd(0, 1, 5'(2*k+1), 32'h0, "init_zero_a_p1");
      if (k < 12) begin
        rd(1, 0, 5'(2*k),   32'h0, "init_zero_b_p0");
        rd(1, 1, 5'(2*k+1), 32'h0, "init_zero_b_p1");
      end
      step();
    end

    // Basic write then read
    we_a = 1; waddr_a = 5; wdata_a = 32'hDEAD_BEEF;
    step();
    we_a = 0;
    rd(0, 0, 5, 32'hDEAD_BEEF, "r5_read");
    step();

    // Zero register vs ordinary r0
    we_a = 1; waddr_a = 0; wdata_a = 32'h0000_1234;
    we_b = 1; waddr_b = 0; wdata_b = 32'h0000_1234;
    step();
    we_a = 0; we_b = 0;
    rd(0, 0, 0, 32'h0,         "zero_reg_a");
    rd(1, 0, 0, 32'h0000_1234, "r0_plain_b");
    step();

    // Same-cycle write/read
    we_a = 1; waddr_a = 7; wdata_a = 32'hA5A5_A5A5;
`ifdef REGFILE_BYPASS_EN
    rd(0, 1, 7, 32'hA5A5_A5A5, "wr_rd_same_cycle");
`else
    rd(0, 1, 7, 32'h0, "wr_rd_same_cycle");
`endif
    rd(0, 0, 5, 32'hDEAD_BEEF, "p0_independent");
    step();
    we_a = 0;
    rd(0, 0, 7, 32'hA5A5_A5A5, "r7_p0_after");
    rd(0, 1, 7, 32'hA5A5_A5A5, "r7_p1_after");
    step();
    we_a = 1; waddr_a = 0; wdata_a = 32'h0000_0055;
    rd(0, 1, 0, 32'h0, "zero_reg_same_cycle");
    step();
    we_a = 1; waddr_a = 31; wdata_a = 32'h3131_3131;
    step();
    we_a = 0;
    rd(0, 0, 31, 32'h3131_3131, "r31_last_entry");
    step();

    // DEPTH=24: out-of-range writes dropped, reads return zero
    we_b = 1; waddr_b = 6;  wdata_b = 32'h0000_0066; step();
    we_b = 1; waddr_b = 23; wdata_b = 32'h2323_2323; step();
    we_b = 1; waddr_b = 30; wdata_b = 32'h0000_0BAD; step();
    we_b = 1; waddr_b = 24; wdata_b = 32'h0000_BAD2; step();
    we_b = 0;
    rd(1, 0, 30, 32'h0, "oob_read_30");
    rd(1, 1, 24, 32'h0, "oob_read_24");
    step();
    for (int k = 0; k < 12; k++) begin
      rd(1, 0, 5'(2*k),   b_exp(2*k),   "b_unchanged_p0");
      rd(1, 1, 5'(2*k+1), b_exp(2*k+1), "b_unchanged_p1");
      step();
    end

    // Fill, then clear request
    for (int k = 1; k <= 3; k++) begin
      we_a = 1; waddr_a = 5'(k); wdata_a = 32'h1111_1111 * k;
      step();
    end
    we_a = 0;
    rd(0, 0, 1, 32'h1111_1111, "fill_r1");
    rd(0, 1, 3, 32'h3333_3333, "fill_r3");
    step();
    clr_req_a = 1;
    step();
    n = 0; done = 0;
    while (!done && n < 100) begin
      clr_req_a = 0; we_a = 0;
      if (ready_a) begin
        done = 1;
      end else begin
        n++;
        if (n == 5) begin
          clr_req_a = 1;
          rd(0, 0, 5, 32'h0, "read_while_clearing");
        end
        if (n == 20) begin
          we_a = 1; waddr_a = 2; wdata_a = 32'h0000_FFFF;
        end
        step();
      end
    end
    clr_req_a = 0; we_a = 0;
    check("clr_req_low_cycles", 32'(n), 32'd32);
    rd(0, 0, 1, 32'h0, "cleared_r1");
    rd(0, 1, 2, 32'h0, "cleared_r2_we_ignored");
    step();
    rd(0, 0, 3, 32'h0, "cleared_r3");
    rd(0, 1, 5, 32'h0, "cleared_r5");
    step();

    // Reset in the middle of a clear
    we_a = 1; waddr_a = 4; wdata_a = 32'h0000_0044;
    step();
    we_a = 0;
    clr_req_a = 1;
    step();
    clr_req_a = 0;
    repeat (9) step();
    rst = 1'b0;
    #2;
    check("midclr_rst_ready", 32'(ready_a), 32'd0);
    check("midclr_rst_rdata0", rdata_a[31:0], 32'h0);
    step();
    step();
    rst = 1'b1;
    n = 0; na = -1;
    while (na < 0 && n < 100) begin
      step();
      n++;
      if (ready_a) na = n;
    end
    check("restart_clear_cycles", 32'(na), 32'd32);
    rd(0, 0, 4, 32'h0, "r4_after_restart");
    rd(0, 1, 7, 32'h0, "r7_after_restart");
    step();

    n = 0;
    while (q_due.size() > 0 && n < 10) begin
      step();
      n++;
    end
    check("scoreboard_drained", 32'(q_due.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
